// File: rtl/piece_queue_ctrl.sv
// Next-piece queue and hold-slot sequencer for the Tetris datapath.
// Optional macro PIECE_QUEUE_NO_REPEAT_EN rejects one immediate repeat from the generator.
module piece_queue_ctrl #(
   parameter int QUEUE_DEPTH = 5,
   parameter int PIECE_W     = 3
) (
   input  logic                               clk_i,
   input  logic                               reset_i,
   input  logic [PIECE_W-1:0]                 gen_piece_i,
   input  logic                               gen_valid_i,
   output logic                               gen_req_o,
   input  logic                               next_req_i,
   input  logic                               hold_req_i,
   output logic [PIECE_W-1:0]                 cur_piece_o,
   output logic [PIECE_W*(QUEUE_DEPTH-1)-1:0] preview_o,
   output logic [PIECE_W-1:0]                 hold_piece_o,
   output logic                               spawn_o,
   output logic                               busy_o,
   output logic                               hold_denied_o
);
   localparam logic [PIECE_W-1:0] EMPTY = {PIECE_W{1'b1}};
   localparam int IDX_W = $clog2(QUEUE_DEPTH);

   typedef enum logic [1:0] {
      S_FILL   = 2'd0,
      S_READY  = 2'd1,
      S_REFILL = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [PIECE_W-1:0] queue_q [QUEUE_DEPTH];
   logic [PIECE_W-1:0] queue_d [QUEUE_DEPTH];
   logic [PIECE_W-1:0] hold_q, hold_d;
   logic               hold_used_q, hold_used_d;
   logic               spawn_q, spawn_d;
   logic               denied_q, denied_d;
   logic               offer_s, accept_s;
   logic [IDX_W-1:0]   fill_idx_s;

   assign gen_req_o     = (state_q != S_READY);
   assign busy_o        = (state_q != S_READY);
   assign cur_piece_o   = queue_q[0];
   assign hold_piece_o  = hold_q;
   assign spawn_o       = spawn_q;
   assign hold_denied_o = denied_q;
   assign offer_s       = gen_req_o && gen_valid_i && (gen_piece_i != EMPTY);

   for (genvar g = 0; g < QUEUE_DEPTH-1; g++) begin : g_preview
      assign preview_o[g*PIECE_W +: PIECE_W] = queue_q[g+1];
   end

`ifdef PIECE_QUEUE_NO_REPEAT_EN
   logic [PIECE_W-1:0] last_q, last_d;
   logic               reroll_q, reroll_d;

   // A repeat of the last accepted piece is let through only on its second consecutive offer.
   assign accept_s = offer_s && ((gen_piece_i != last_q) || reroll_q);

   // Next-state for the last-accepted piece and the reroll flag.
   always_comb begin
      last_d   = last_q;
      reroll_d = reroll_q;
      if (accept_s) begin
         last_d   = gen_piece_i;
         reroll_d = 1'b0;
      end else if (offer_s) begin
         reroll_d = 1'b1;
      end else begin
         reroll_d = reroll_q;
      end
   end

   // Repeat-filter state registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         last_q   <= EMPTY;
         reroll_q <= 1'b0;
      end else begin
         last_q   <= last_d;
         reroll_q <= reroll_d;
      end
   end
`else
   assign accept_s = offer_s;
`endif

   // Lowest EMPTY entry; the queue fills head-first so this is the fill pointer.
   always_comb begin
      fill_idx_s = IDX_W'(0);
      for (int i = QUEUE_DEPTH-1; i >= 0; i--) begin
         if (queue_q[i] == EMPTY) begin
            fill_idx_s = IDX_W'(i);
         end else begin
            fill_idx_s = fill_idx_s;
         end
      end
   end

   // Queue, hold slot and FSM next-state.
   always_comb begin
      state_d     = state_q;
      queue_d     = queue_q;
      hold_d      = hold_q;
      hold_used_d = hold_used_q;
      spawn_d     = 1'b0;
      denied_d    = 1'b0;
      case (state_q)
         S_FILL: begin
            if (accept_s) begin
               queue_d[fill_idx_s] = gen_piece_i;
               if (fill_idx_s == IDX_W'(QUEUE_DEPTH-1)) begin
                  state_d = S_READY;
                  spawn_d = 1'b1;
               end else begin
                  state_d = S_FILL;
               end
            end else begin
               state_d = S_FILL;
            end
         end
         S_READY: begin
            if (next_req_i || (hold_req_i && !hold_used_q && (hold_q == EMPTY))) begin
               // Lock and first hold both advance the queue and wait for a new tail.
               for (int i = 0; i < QUEUE_DEPTH-1; i++) begin
                  queue_d[i] = queue_q[i+1];
               end
               queue_d[QUEUE_DEPTH-1] = EMPTY;
               state_d                = S_REFILL;
               if (next_req_i) begin
                  hold_used_d = 1'b0;
                  denied_d    = hold_req_i;
               end else begin
                  hold_d      = queue_q[0];
                  hold_used_d = 1'b1;
               end
            end else if (hold_req_i) begin
               if (hold_used_q) begin
                  denied_d = 1'b1;
               end else begin
                  queue_d[0]  = hold_q;
                  hold_d      = queue_q[0];
                  hold_used_d = 1'b1;
                  spawn_d     = 1'b1;
               end
            end else begin
               state_d = S_READY;
            end
         end
         S_REFILL: begin
            if (accept_s) begin
               queue_d[QUEUE_DEPTH-1] = gen_piece_i;
               state_d                = S_READY;
               spawn_d                = 1'b1;
            end else begin
               state_d = S_REFILL;
            end
         end
         default: begin
            state_d = S_FILL;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= S_FILL;
         hold_q      <= EMPTY;
         hold_used_q <= 1'b0;
         spawn_q     <= 1'b0;
         denied_q    <= 1'b0;
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            queue_q[i] <= EMPTY;
         end
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_used_q <= hold_used_d;
         spawn_q     <= spawn_d;
         denied_q    <= denied_d;
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            queue_q[i] <= queue_d[i];
         end
      end
   end
endmodule

// File: tb/tb_piece_queue_ctrl.sv
// Table-driven bench for piece_queue_ctrl: one record per clock of inputs and expected outputs.
module tb_piece_queue_ctrl;
   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  gen_piece;
   logic        gen_valid;
   logic        gen_req;
   logic        next_req;
   logic        hold_req;
   logic [2:0]  cur_piece;
   logic [11:0] preview;
   logic [2:0]  hold_piece;
   logic        spawn;
   logic        busy;
   logic        hold_denied;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        rst;
      logic        gv;
      logic [2:0]  gp;
      logic        nx;
      logic        hd;
      logic [2:0]  cur;
      logic [11:0] pv;
      logic [2:0]  hold;
      logic        spawn;
      logic        busy;
      logic        den;
   } vec_t;

   vec_t vecs [28];

   piece_queue_ctrl #(.QUEUE_DEPTH(5), .PIECE_W(3)) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .gen_piece_i   (gen_piece),
      .gen_valid_i   (gen_valid),
      .gen_req_o     (gen_req),
      .next_req_i    (next_req),
      .hold_req_i    (hold_req),
      .cur_piece_o   (cur_piece),
      .preview_o     (preview),
      .hold_piece_o  (hold_piece),
      .spawn_o       (spawn),
      .busy_o        (busy),
      .hold_denied_o (hold_denied)
   );

   always #5 clk = ~clk;

   // Entry 1 sits in the LSBs of preview.
   function automatic logic [11:0] pv(input int e1, input int e2, input int e3, input int e4);
      return {3'(e4), 3'(e3), 3'(e2), 3'(e1)};
   endfunction

   function automatic vec_t mk(input int rst, input int gv, input int gp, input int nx,
                               input int hd, input int cur, input logic [11:0] p,
                               input int hold, input int sp, input int bz, input int dn);
      vec_t v;
      v.rst   = 1'(rst);
      v.gv    = 1'(gv);
      v.gp    = 3'(gp);
      v.nx    = 1'(nx);
      v.hd    = 1'(hd);
      v.cur   = 3'(cur);
      v.pv    = p;
      v.hold  = 3'(hold);
      v.spawn = 1'(sp);
      v.busy  = 1'(bz);
      v.den   = 1'(dn);
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input string tag);
      reset     = v.rst;
      gen_valid = v.gv;
      gen_piece = v.gp;
      next_req  = v.nx;
      hold_req  = v.hd;
      @(posedge clk);
      #1;
      check({tag, ".cur"},     32'(cur_piece),   32'(v.cur));
      check({tag, ".preview"}, 32'(preview),     32'(v.pv));
      check({tag, ".hold"},    32'(hold_piece),  32'(v.hold));
      check({tag, ".spawn"},   32'(spawn),       32'(v.spawn));
      check({tag, ".busy"},    32'(busy),        32'(v.busy));
      check({tag, ".gen_req"}, 32'(gen_req),     32'(v.busy));
      check({tag, ".denied"},  32'(hold_denied), 32'(v.den));
   endtask

   initial begin
      reset     = 1'b1;
      gen_valid = 1'b0;
      gen_piece = 3'd0;
      next_req  = 1'b0;
      hold_req  = 1'b0;

      //             rst gv gp nx hd  cur preview          hold sp bz dn
      vecs[0]  = mk(1, 0, 0, 0, 0,  7, pv(7, 7, 7, 7), 7, 0, 1, 0);
      vecs[1]  = mk(0, 1, 2, 0, 0,  2, pv(7, 7, 7, 7), 7, 0, 1, 0);
      vecs[2]  = mk(0, 1, 5, 0, 0,  2, pv(5, 7, 7, 7), 7, 0, 1, 0);
      vecs[3]  = mk(0, 1, 0, 0, 0,  2, pv(5, 0, 7, 7), 7, 0, 1, 0);
      vecs[4]  = mk(0, 1, 7, 0, 0,  2, pv(5, 0, 7, 7), 7, 0, 1, 0);
      vecs[5]  = mk(0, 1, 6, 1, 1,  2, pv(5, 0, 6, 7), 7, 0, 1, 0);
      vecs[6]  = mk(0, 1, 3, 0, 0,  2, pv(5, 0, 6, 3), 7, 1, 0, 0);
      vecs[7]  = mk(0, 0, 0, 0, 0,  2, pv(5, 0, 6, 3), 7, 0, 0, 0);
      vecs[8]  = mk(0, 0, 0, 1, 0,  5, pv(0, 6, 3, 7), 7, 0, 1, 0);
      vecs[9]  = mk(0, 1, 4, 0, 0,  5, pv(0, 6, 3, 4), 7, 1, 0, 0);
      vecs[10] = mk(0, 0, 0, 0, 1,  0, pv(6, 3, 4, 7), 5, 0, 1, 0);
      vecs[11] = mk(0, 0, 0, 0, 1,  0, pv(6, 3, 4, 7), 5, 0, 1, 0);
      vecs[12] = mk(0, 1, 1, 0, 0,  0, pv(6, 3, 4, 1), 5, 1, 0, 0);
      vecs[13] = mk(0, 0, 0, 0, 1,  0, pv(6, 3, 4, 1), 5, 0, 0, 1);
      vecs[14] = mk(0, 0, 0, 0, 0,  0, pv(6, 3, 4, 1), 5, 0, 0, 0);
      vecs[15] = mk(0, 0, 0, 1, 0,  6, pv(3, 4, 1, 7), 5, 0, 1, 0);
      vecs[16] = mk(0, 1, 2, 0, 0,  6, pv(3, 4, 1, 2), 5, 1, 0, 0);
      vecs[17] = mk(0, 0, 0, 0, 1,  5, pv(3, 4, 1, 2), 6, 1, 0, 0);
      vecs[18] = mk(0, 0, 0, 0, 1,  5, pv(3, 4, 1, 2), 6, 0, 0, 1);
      vecs[19] = mk(0, 0, 0, 0, 0,  5, pv(3, 4, 1, 2), 6, 0, 0, 0);
      vecs[20] = mk(0, 0, 0, 1, 1,  3, pv(4, 1, 2, 7), 6, 0, 1, 1);
      vecs[21] = mk(0, 0, 0, 0, 0,  3, pv(4, 1, 2, 7), 6, 0, 1, 0);
      vecs[22] = mk(0, 1, 7, 0, 0,  3, pv(4, 1, 2, 7), 6, 0, 1, 0);
      vecs[23] = mk(0, 1, 0, 0, 0,  3, pv(4, 1, 2, 0), 6, 1, 0, 0);
      vecs[24] = mk(0, 1, 5, 0, 0,  3, pv(4, 1, 2, 0), 6, 0, 0, 0);
      vecs[25] = mk(0, 0, 0, 1, 0,  4, pv(1, 2, 0, 7), 6, 0, 1, 0);
      vecs[26] = mk(1, 1, 5, 0, 0,  7, pv(7, 7, 7, 7), 7, 0, 1, 0);
      vecs[27] = mk(0, 0, 0, 0, 0,  7, pv(7, 7, 7, 7), 7, 0, 1, 0);

      @(posedge clk);
      #1;
      for (int i = 0; i < 28; i++) begin
         apply(vecs[i], $sformatf("v%0d", i));
      end

      // Generator offers the same piece three times in a row.
      apply(mk(1, 0, 0, 0, 0, 7, pv(7, 7, 7, 7), 7, 0, 1, 0), "rep_rst");
      apply(mk(0, 1, 3, 0, 0, 3, pv(7, 7, 7, 7), 7, 0, 1, 0), "rep1");
`ifdef PIECE_QUEUE_NO_REPEAT_EN
      apply(mk(0, 1, 3, 0, 0, 3, pv(7, 7, 7, 7), 7, 0, 1, 0), "rep2");
      apply(mk(0, 1, 3, 0, 0, 3, pv(3, 7, 7, 7), 7, 0, 1, 0), "rep3");
`else
      apply(mk(0, 1, 3, 0, 0, 3, pv(3, 7, 7, 7), 7, 0, 1, 0), "rep2");
      apply(mk(0, 1, 3, 0, 0, 3, pv(3, 3, 7, 7), 7, 0, 1, 0), "rep3");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/piece_queue_ctrl.md
Name: piece_queue_ctrl

Overview:
- Sequences the next-piece queue and the hold slot of the Tetris datapath.
- Fills the queue from the random piece generator and advances it on piece lock.
- Performs hold swaps, enforcing one hold per spawned piece.
- Emits a one-cycle spawn pulse to the playfield logic whenever the current piece changes.

Parameters:
- QUEUE_DEPTH, 5, number of queue entries: current piece plus QUEUE_DEPTH-1 preview pieces; legal range 2..8.
- PIECE_W, 3, piece code width. Codes 0..6 are the seven tetrominoes; code 7 (all ones) is EMPTY.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- gen_piece  input  PIECE_W  piece code from the random generator.
- gen_valid  input  1  gen_piece is valid this cycle.
- gen_req  output  1  controller will accept a generator piece this cycle.
- next_req  input  1  current piece has locked; advance the queue.
- hold_req  input  1  player requests a hold swap.
- cur_piece  output  PIECE_W  queue head (active piece).
- preview  output  PIECE_W*(QUEUE_DEPTH-1)  entries 1..DEPTH-1; entry 1 is in the LSBs.
- hold_piece  output  PIECE_W  hold slot contents.
- spawn  output  1  one-cycle pulse: cur_piece is newly valid.
- busy  output  1  in FILL or REFILL; requests are ignored.
- hold_denied  output  1  one-cycle pulse: hold_req rejected.

Behaviour:
- Reset value of every output and register:
  - all queue entries = 7, hold_piece = 7, hold_used = 0;
  - spawn = 0, hold_denied = 0, busy = 1, gen_req = 1;
  - state = FILL.
  - Reset mid-operation discards all contents.
- States: FILL, READY, REFILL. gen_req = busy = (state != READY).
- Accept rule: a generator piece is accepted when gen_req && gen_valid && gen_piece != 7. A gen_piece of 7 is discarded; the bench must see no state change.
- FILL:
  - Each accepted piece enters the lowest EMPTY entry; the head fills first.
  - When the last entry fills, go to READY next cycle with spawn = 1 for exactly that one cycle.
  - next_req and hold_req are ignored in FILL, with no hold_denied pulse.
- READY, next_req = 1:
  - Shift the queue toward the head; the tail becomes 7; clear hold_used; go to REFILL.
- READY, hold_req = 1 (and no next_req):
  - hold_used = 1: ignore the request; pulse hold_denied next cycle.
  - hold_used = 0 and hold_piece = 7: hold_piece <= head; shift the queue as for next_req; hold_used <= 1; go to REFILL.
  - hold_used = 0 and hold_piece != 7: swap head and hold_piece in one cycle; hold_used <= 1; spawn = 1 next cycle; stay in READY.
- Simultaneous next_req and hold_req: next_req wins; hold_req is ignored and pulses hold_denied.
- REFILL:
  - The first accepted piece fills the tail.
  - Return to READY with spawn = 1 in the following cycle.
  - Minimum latency from next_req to spawn is 2 cycles when gen_valid is held high.
  - While waiting: cur_piece already shows the new head; spawn stays 0; requests are ignored.
- hold_used is cleared only by next_req or reset; a swap never clears it.
- spawn and hold_denied are never high in consecutive cycles from a single request.
- Outputs are registered; no combinational path from any input to any output except gen_req (state only).

Optional Feature:
- Macro: PIECE_QUEUE_NO_REPEAT_EN.
- When defined:
  - An incoming gen_piece equal to the piece most recently accepted into the queue is discarded and treated as not accepted.
  - A repeat is accepted only if it is the second consecutive repeat offered; a 1-bit reroll flag permits this, bounding rejection to one piece.
  - The reroll flag is cleared on accept and on reset.
- When undefined: all gen_piece codes 0..6 are accepted unconditionally; no reroll logic is present.

Test Plan:
- Reset, then gen_valid = 1 with pieces 2,5,0,6,3: 5 cycles later cur_piece = 2, preview = {3,6,0,5} (entry 1 = 5), spawn pulses once, busy falls.
- From the above state, next_req pulse, then gen_piece = 4 one cycle later: cur_piece = 5, tail = 4, spawn 2 cycles after next_req, hold_used cleared.
- Hold with empty slot: hold_req from cur_piece = 5 → hold_piece = 5, cur_piece = 0, REFILL. Second hold_req after spawn → hold_denied pulse, state unchanged. After next_req, hold_req swaps: cur_piece = 5, hold_piece = old head, spawn next cycle.
- Simultaneous next_req and hold_req in READY: queue advances; hold_piece unchanged; hold_denied pulses once.
- gen_piece = 7 during FILL: ignored, no entry written. Reset asserted mid-REFILL: all entries, hold_piece = 7; state = FILL next cycle.
- With PIECE_QUEUE_NO_REPEAT_EN: offer 3,3,3 → first 3 accepted, second discarded, third accepted; without the macro, all three are accepted.
